// File: rtl/spi_reg_pkg.sv
// Shared constants and types for the SPI register controller.
package spi_reg_pkg;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned REG_COUNT  = 5;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned DATA_W     = 8;

    // Bit counter saturates one past a full frame so long frames stay detectable.
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } spi_state_t;

endpackage

// File: rtl/sync_bit.sv
// Flop-chain synchroniser for one asynchronous input, cleared by reset.
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 write-only slave committing 16-bit frames into five config registers.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [6:0]  MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       ncs,
    input  logic       copi,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic       frame_err
);

    logic sclk_s, ncs_s, copi_s;
    logic sclk_d, ncs_d, copi_d;
    logic sclk_rise, ncs_rise, ncs_fall;

    spi_state_t             state, state_next;
    logic [FRAME_BITS-1:0]  shift, shift_next;
    logic [CNT_W-1:0]       bit_cnt, cnt_next;
    logic                   wr_next, err_next;
    logic [ADDR_W-1:0]      frame_addr;
    logic [DATA_W-1:0]      frame_data;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s));
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ncs  (.clk(clk), .rst_n(rst_n), .d(ncs),  .q(ncs_s));
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_copi (.clk(clk), .rst_n(rst_n), .d(copi), .q(copi_s));

    // Delay flops for edge detection; copi delayed too so data lines up with the sclk detect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_d <= 1'b0;
            ncs_d  <= 1'b0;
            copi_d <= 1'b0;
        end else begin
            sclk_d <= sclk_s;
            ncs_d  <= ncs_s;
            copi_d <= copi_s;
        end
    end

    assign sclk_rise  = sclk_s & ~sclk_d;
    assign ncs_rise   = ncs_s & ~ncs_d;
    assign ncs_fall   = ~ncs_s & ncs_d;
    assign frame_addr = shift[FRAME_BITS-2 -: ADDR_W];
    assign frame_data = shift[DATA_W-1:0];

    // State, shift register, counter and strobe registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift     <= '0;
            bit_cnt   <= '0;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            shift     <= shift_next;
            bit_cnt   <= cnt_next;
            wr_strobe <= wr_next;
            frame_err <= err_next;
        end
    end

    // Next-state, frame capture and commit decision.
    always_comb begin
        state_next = state;
        shift_next = shift;
        cnt_next   = bit_cnt;
        wr_next    = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (ncs_fall) begin
                    state_next = SHIFT;
                    shift_next = '0;
                    cnt_next   = '0;
                end
            end
            SHIFT: begin
                if (ncs_fall) begin
                    shift_next = '0;
                    cnt_next   = '0;
                end else if (ncs_rise) begin
                    state_next = COMMIT;
                end else if (sclk_rise) begin
                    shift_next = {shift[FRAME_BITS-2:0], copi_d};
                    if (bit_cnt != CNT_SAT) begin
                        cnt_next = bit_cnt + CNT_W'(1);
                    end
                end
            end
            COMMIT: begin
                state_next = IDLE;
                if (bit_cnt != CNT_W'(FRAME_BITS)) begin
                    err_next = 1'b1;
                end else if (shift[FRAME_BITS-1]) begin
                    if (frame_addr <= MAX_ADDR) begin
                        wr_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Register file: updated only in the cycle leaving COMMIT with a valid write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_reg_out_7_0  <= '0;
            en_reg_out_15_8 <= '0;
            en_reg_pwm_7_0  <= '0;
            en_reg_pwm_15_8 <= '0;
            pwm_duty_cycle  <= '0;
        end else if (wr_next) begin
            case (frame_addr)
                ADDR_EN_OUT_LO: en_reg_out_7_0  <= frame_data;
                ADDR_EN_OUT_HI: en_reg_out_15_8 <= frame_data;
                ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= frame_data;
                ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= frame_data;
                ADDR_DUTY:      pwm_duty_cycle  <= frame_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: table of frames plus reset and timing corner cases.
module tb_spi_reg_ctrl;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       ncs;
    logic       copi;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_strobe;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    typedef struct {
        logic [16:0] bits;
        int          nbits;
        logic [39:0] exp_regs;
        int          exp_wr;
        int          exp_err;
    } vec_t;

    vec_t vecs [8];

    spi_reg_ctrl #(.SYNC_STAGES(2), .MAX_ADDR(7'h04)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sclk            (sclk),
        .ncs             (ncs),
        .copi            (copi),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .wr_strobe       (wr_strobe),
        .frame_err       (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_strobe) wr_cnt++;
        if (frame_err) err_cnt++;
        if (wr_strobe && frame_err) both_cnt++;
    end

    function automatic logic [39:0] regs_now();
        return {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic spi_bits(input logic [16:0] v, input int n, input int half);
        for (int i = n - 1; i >= 0; i--) begin
            copi = v[i];
            tick(half);
            sclk = 1'b1;
            tick(half);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_frame(input logic [16:0] v, input int n, input int half, input int gap);
        ncs = 1'b0;
        tick(half);
        spi_bits(v, n, half);
        tick(half);
        ncs = 1'b1;
        tick(gap);
    endtask

    initial begin
        int wr0, er0;

        vecs[0] = '{17'h080F0, 16, 40'hF0_00_00_00_00, 1, 0};
        vecs[1] = '{17'h08455, 16, 40'hF0_00_00_00_55, 1, 0};
        vecs[2] = '{17'h04155, 15, 40'hF0_00_00_00_55, 0, 1};  // 15-bit: top bits of 0x82AA
        vecs[3] = '{17'h10554, 17, 40'hF0_00_00_00_55, 0, 1};  // 17-bit: 0x82AA then a 0
        vecs[4] = '{17'h08577, 16, 40'hF0_00_00_00_55, 0, 1};  // address 0x05
        vecs[5] = '{17'h00277, 16, 40'hF0_00_00_00_55, 0, 0};  // read frame
        vecs[6] = '{17'h08112, 16, 40'hF0_12_00_00_55, 1, 0};
        vecs[7] = '{17'h08234, 16, 40'hF0_12_34_00_55, 1, 0};

        rst_n = 1'b0;
        sclk  = 1'b0;
        ncs   = 1'b1;
        copi  = 1'b0;
        tick(5);
        check("reset_regs", regs_now(), 40'h0);
        rst_n = 1'b1;
        tick(5);

        // sclk activity with ncs high must be ignored
        wr0 = wr_cnt; er0 = err_cnt;
        spi_bits(17'h000FF, 8, 6);
        copi = 1'b1;
        tick(12);
        check("idle_regs", regs_now(), 40'h0);
        check("idle_wr", 40'(wr_cnt - wr0), 40'h0);
        check("idle_err", 40'(err_cnt - er0), 40'h0);

        for (int k = 0; k < 8; k++) begin
            wr0 = wr_cnt; er0 = err_cnt;
            spi_frame(vecs[k].bits, vecs[k].nbits, 6, 10);
            check($sformatf("vec%0d_regs", k), regs_now(), vecs[k].exp_regs);
            check($sformatf("vec%0d_wr", k), 40'(wr_cnt - wr0), 40'(vecs[k].exp_wr));
            check($sformatf("vec%0d_err", k), 40'(err_cnt - er0), 40'(vecs[k].exp_err));
        end

        // Reset in the middle of 0x8333, then finish the remaining bits
        wr0 = wr_cnt; er0 = err_cnt;
        ncs = 1'b0;
        tick(6);
        spi_bits(17'h00083, 8, 6);
        rst_n = 1'b0;
        tick(3);
        check("midrst_regs_in_reset", regs_now(), 40'h0);
        rst_n = 1'b1;
        spi_bits(17'h00033, 8, 6);
        tick(6);
        ncs = 1'b1;
        tick(12);
        check("midrst_regs_after", regs_now(), 40'h0);
        check("midrst_wr", 40'(wr_cnt - wr0), 40'h0);
        check("midrst_err", 40'(err_cnt - er0), 40'h0);

        wr0 = wr_cnt; er0 = err_cnt;
        spi_frame(17'h08366, 16, 6, 10);
        check("post_rst_write", regs_now(), 40'h00_00_00_66_00);
        check("post_rst_wr", 40'(wr_cnt - wr0), 40'h1);

        // Back-to-back at the minimum timing
        wr0 = wr_cnt; er0 = err_cnt;
        for (int a = 0; a < 5; a++) begin
            logic [16:0] f;
            f = {1'b0, 1'b1, 7'(a), 8'(a + 1)};
            spi_frame(f, 16, 4, 5);
        end
        tick(10);
        check("b2b_regs", regs_now(), 40'h01_02_03_04_05);
        check("b2b_wr", 40'(wr_cnt - wr0), 40'h5);
        check("b2b_err", 40'(err_cnt - er0), 40'h0);
        check("strobe_overlap", 40'(both_cnt), 40'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

SPI-slave register controller that configures the PWM peripheral. It receives 16-bit write frames from an external SPI host on three asynchronous pins and synchronises them into the `clk` domain. Validated writes are committed into five 8-bit configuration registers, which drive the PWM peripheral's output-enable, PWM-enable and duty-cycle inputs directly. It sits between the top-level `ui_in` pins and `pwm_peripheral`.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flops per input synchroniser, before the edge-detect flop. Minimum 2.
- `MAX_ADDR`, default 7'h04: highest valid register address.

Ports:
- `clk`  in  1  system clock. Sole clock of the block.
- `rst_n`  in  1  reset. Synchronous, active-low.
- `sclk`  in  1  SPI clock, asynchronous to `clk`. SPI mode 0: idle low, data sampled on the rising edge.
- `ncs`  in  1  SPI chip select, active-low, asynchronous.
- `copi`  in  1  SPI data in, MSB first, asynchronous.
- `en_reg_out_7_0`  out  8  register at address 0x00.
- `en_reg_out_15_8`  out  8  register at address 0x01.
- `en_reg_pwm_7_0`  out  8  register at address 0x02.
- `en_reg_pwm_15_8`  out  8  register at address 0x03.
- `pwm_duty_cycle`  out  8  register at address 0x04.
- `wr_strobe`  out  1  one-cycle pulse in the cycle a register is updated.
- `frame_err`  out  1  one-cycle pulse when a frame is discarded.

## Operation
- **Synchroniser:** each of `sclk`, `ncs` and `copi` passes through a `SYNC_STAGES` flop chain plus one delay flop, giving rise and fall detects on `sclk` and `ncs`.
- **Frame format:** bit15 = R/W (1 = write); bits14:8 = address (7 bits); bits7:0 = data.
- **States:**
  - IDLE → SHIFT on the `ncs` fall detect; the shift register and bit counter clear.
  - SHIFT: on each `sclk` rise detect, `shift <= {shift[14:0], copi_sync}` and `bit_cnt` increments. `bit_cnt` is 5 bits and saturates at 17.
  - SHIFT → COMMIT on the `ncs` rise detect.
  - COMMIT → IDLE unconditionally, after one cycle.
- **COMMIT rules:**
  - `bit_cnt==16`, bit15=1 and address ≤ `MAX_ADDR`: write the data byte to the addressed register and pulse `wr_strobe`.
  - `bit_cnt!=16` (short, or long with count saturated at 17): no write; pulse `frame_err`.
  - `bit_cnt==16` and bit15=0 (read): ignored. No write, no error, because the block is write-only.
  - `bit_cnt==16`, bit15=1 and address > `MAX_ADDR`: no write; pulse `frame_err`.
- **Edge cases:**
  - `sclk` edges while in IDLE (`ncs` high) are ignored.
  - An `ncs` fall detect while in SHIFT restarts the frame (counter cleared).
- **Reset values:** all five registers 0x00, `wr_strobe`=0, `frame_err`=0, state IDLE, shift register and counter 0.
- **Reset mid-frame:** the partial frame is discarded and registers return to 0x00. A frame in progress when `rst_n` rises is ignored until the next `ncs` fall.
- **Register updates:** registers change only in COMMIT. Outputs are glitch-free and directly registered.

## Timing
- `sclk` high and low phases must each be ≥ (`SYNC_STAGES`+2) `clk` periods. `ncs` setup before the first `sclk` rise, and hold after the last `sclk` fall, must meet the same bound.
- `copi` must be stable from ≥ (`SYNC_STAGES`+2) `clk` periods before each `sclk` rise until that rise is detected.
- **Commit latency:** with `SYNC_STAGES`=2, the `ncs` rise is detected in the cycle after the 2nd clock edge that samples `ncs` high. COMMIT is entered on the 3rd edge. The register, `wr_strobe` or `frame_err` are visible after the 4th edge.
- `wr_strobe` and `frame_err` are mutually exclusive and each exactly one cycle wide.
- Minimum frame spacing: `ncs` high ≥ (`SYNC_STAGES`+3) `clk` periods.

## Structure
- **Package `spi_reg_pkg`:**
  - `localparam`s `ADDR_EN_OUT_LO`=7'h00 … `ADDR_DUTY`=7'h04, `FRAME_BITS`=16, `REG_COUNT`=5.
  - `typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} spi_state_t`.
- **Sub-module `sync_bit`:** parameterised flop-chain synchroniser with synchronous active-low reset to 0. Instantiated once each for `sclk`, `ncs` and `copi`.
- Edge detect, FSM, shift register, counter and register file live in `spi_reg_ctrl`.

## Test plan
- **Reset:** after reset, drive a 0xFF pattern on `copi` with `ncs` high → all registers 0x00, no strobes.
- **Valid writes:** write 0x80F0 then 0x8455 → `en_reg_out_7_0`=0xF0, `pwm_duty_cycle`=0x55, one `wr_strobe` per frame, other registers 0x00.
- **Short and long frames:** a 15-bit frame and a 17-bit frame, each targeting address 0x02 with 0xAA → `en_reg_pwm_7_0` stays 0x00, one `frame_err` each.
- **Bad address and read:** frame 0x8577 (address 0x05) → `frame_err`, no change. Frame 0x0277 (read) → no strobe, no change.
- **Reset mid-frame:** assert `rst_n`=0 after 8 bits of 0x8333 → all registers 0x00. The next full frame 0x8366 → `en_reg_pwm_15_8`=0x66.
- **Back-to-back at minimum timing:** `sclk` phases of exactly 4 `clk` periods and `ncs` gaps of 5, writing 0x8001–0x8405 → registers equal 0x01–0x05, five `wr_strobe` pulses.
